mem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the 256 x 8-bit byte memory.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-requester byte-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Transaction header latched at grant time
  typedef struct packed {
    req_id_e             id;
    logic                wr;
    logic                oob;
    logic [ADDR_W-1:0]   addr;
  } txn_hdr_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie, the requester not served last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_gnt_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = req_a_i | req_b_i;
    gnt_id_o    = REQ_A;
    if (req_a_i && req_b_i) begin
      gnt_id_o = (last_gnt_i == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b_i) begin
      gnt_id_o = REQ_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises W-bit word accesses into little-endian byte beats.
// Optional MEM_ARB_BOUNDS_EN: requests running past address 0xFF are rejected with err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_wrt_enable,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [W-1:0]      a_wrt_data,
  output logic              a_ack,
  output logic [W-1:0]      a_read_data,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_wrt_enable,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [W-1:0]      b_wrt_data,
  output logic              b_ack,
  output logic [W-1:0]      b_read_data,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wrt_enable,
  output logic [BYTE_W-1:0] mem_wrt_data,
  input  logic [BYTE_W-1:0] mem_read_data,
  output logic              busy
);

  localparam int unsigned BYTES  = W / BYTE_W;
  localparam int unsigned BEAT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_gnt_q, last_gnt_d;
  txn_hdr_t            txn_q, txn_d;
  logic [W-1:0]        wdata_q, wdata_d;
  logic [W-1:0]        rdata_q, rdata_d;

  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                mem_wrt_enable_q, mem_wrt_enable_d;
  logic [BYTE_W-1:0]   mem_wrt_data_q, mem_wrt_data_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic                a_err_q, a_err_d, b_err_q, b_err_d;
  logic [W-1:0]        a_read_data_q, a_read_data_d;
  logic [W-1:0]        b_read_data_q, b_read_data_d;
  logic                busy_q, busy_d;

  logic gnt_valid;
  logic gnt_id;
  logic oob;

  mem_arb_rr u_rr (
    .req_a_i     (a_req),
    .req_b_i     (b_req),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

`ifdef MEM_ARB_BOUNDS_EN
  localparam int unsigned EXT_W = ADDR_W + 1;
  logic [EXT_W-1:0] last_addr;
  // Carry out of the 8-bit address space flags a request that would wrap
  assign last_addr = {1'b0, (gnt_id ? b_address : a_address)} + EXT_W'(BYTES - 1);
  assign oob       = last_addr[ADDR_W];
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      last_gnt_q       <= REQ_B;
      txn_q            <= '0;
      wdata_q          <= '0;
      rdata_q          <= '0;
      mem_address_q    <= '0;
      mem_wrt_enable_q <= 1'b0;
      mem_wrt_data_q   <= '0;
      a_ack_q          <= 1'b0;
      b_ack_q          <= 1'b0;
      a_err_q          <= 1'b0;
      b_err_q          <= 1'b0;
      a_read_data_q    <= '0;
      b_read_data_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      last_gnt_q       <= last_gnt_d;
      txn_q            <= txn_d;
      wdata_q          <= wdata_d;
      rdata_q          <= rdata_d;
      mem_address_q    <= mem_address_d;
      mem_wrt_enable_q <= mem_wrt_enable_d;
      mem_wrt_data_q   <= mem_wrt_data_d;
      a_ack_q          <= a_ack_d;
      b_ack_q          <= b_ack_d;
      a_err_q          <= a_err_d;
      b_err_q          <= b_err_d;
      a_read_data_q    <= a_read_data_d;
      b_read_data_q    <= b_read_data_d;
      busy_q           <= busy_d;
    end
  end

  // Next-state: grant and latch in IDLE, walk beats in XFER, retire in DONE
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_gnt_d = last_gnt_q;
    txn_d      = txn_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          txn_d.id   = gnt_id ? REQ_B : REQ_A;
          txn_d.wr   = gnt_id ? b_wrt_enable : a_wrt_enable;
          txn_d.addr = gnt_id ? b_address : a_address;
          txn_d.oob  = oob;
          wdata_d    = gnt_id ? b_wrt_data : a_wrt_data;
          beat_d     = '0;
          state_d    = oob ? DONE : XFER;
        end
      end
      XFER: begin
        if (!txn_q.wr) begin
          rdata_d[BYTE_W*beat_q +: BYTE_W] = mem_read_data;
        end
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        last_gnt_d = txn_q.id;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so beats line up with XFER cycles
  always_comb begin
    mem_address_d    = '0;
    mem_wrt_enable_d = 1'b0;
    mem_wrt_data_d   = '0;
    a_ack_d          = 1'b0;
    b_ack_d          = 1'b0;
    a_err_d          = 1'b0;
    b_err_d          = 1'b0;
    a_read_data_d    = a_read_data_q;
    b_read_data_d    = b_read_data_q;
    busy_d           = (state_d != IDLE);
    if (state_d == XFER) begin
      mem_address_d    = txn_d.addr + ADDR_W'(beat_d);
      mem_wrt_enable_d = txn_d.wr;
      if (txn_d.wr) begin
        mem_wrt_data_d = wdata_d[BYTE_W*beat_d +: BYTE_W];
      end
    end
    if (state_d == DONE) begin
      a_ack_d = (txn_d.id == REQ_A);
      b_ack_d = (txn_d.id == REQ_B);
      a_err_d = a_ack_d & txn_d.oob;
      b_err_d = b_ack_d & txn_d.oob;
      if (!txn_d.wr && !txn_d.oob) begin
        if (txn_d.id == REQ_A) begin
          a_read_data_d = rdata_d;
        end else begin
          b_read_data_d = rdata_d;
        end
      end
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_wrt_enable = mem_wrt_enable_q;
  assign mem_wrt_data   = mem_wrt_data_q;
  assign a_ack          = a_ack_q;
  assign b_ack          = b_ack_q;
  assign a_err          = a_err_q;
  assign b_err          = b_err_q;
  assign a_read_data    = a_read_data_q;
  assign b_read_data    = b_read_data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (W=32) with a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned W     = 32;
  localparam int unsigned BYTES = W / 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_req, a_wrt_enable, b_req, b_wrt_enable;
  logic [7:0]   a_address, b_address;
  logic [W-1:0] a_wrt_data, b_wrt_data;
  logic         a_ack, a_err, b_ack, b_err;
  logic [W-1:0] a_read_data, b_read_data;
  logic [7:0]   mem_address, mem_wrt_data, mem_read_data;
  logic         mem_wrt_enable, busy;

  mem_arbiter #(.W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_req          (a_req),
    .a_wrt_enable   (a_wrt_enable),
    .a_address      (a_address),
    .a_wrt_data     (a_wrt_data),
    .a_ack          (a_ack),
    .a_read_data    (a_read_data),
    .a_err          (a_err),
    .b_req          (b_req),
    .b_wrt_enable   (b_wrt_enable),
    .b_address      (b_address),
    .b_wrt_data     (b_wrt_data),
    .b_ack          (b_ack),
    .b_read_data    (b_read_data),
    .b_err          (b_err),
    .mem_address    (mem_address),
    .mem_wrt_enable (mem_wrt_enable),
    .mem_wrt_data   (mem_wrt_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Byte memory attached to the DUT, plus the model's view of it
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_wrt_enable) mem[mem_address] <= mem_wrt_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    int           id;
    int           cyc;
    logic         err;
    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;
  } ack_t;

  beat_t        beat_q[$];
  ack_t         ack_q[$];
  int           checks = 0;
  int           errors = 0;
  int           last_id = 1;
  logic [W-1:0] exp_rd [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model one transaction; returns the cycle in which its ack is observed
  function automatic int model_txn(input int id, input bit wr, input logic [7:0] addr,
                                   input logic [W-1:0] data, input int g);
    ack_t         e;
    logic [W-1:0] rd = '0;
    bit           oob = 1'b0;
`ifdef MEM_ARB_BOUNDS_EN
    oob = (int'(addr) + int'(BYTES) - 1) > 255;
`endif
    if (!oob) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        logic [7:0] a = addr + 8'(i);
        if (wr) begin
          beat_q.push_back('{g + i, a, data[8*i +: 8]});
          ref_mem[a] = data[8*i +: 8];
        end else begin
          rd[8*i +: 8] = ref_mem[a];
        end
      end
      if (!wr) exp_rd[id] = rd;
    end
    last_id = id;
    e = '{id, g + (oob ? 0 : int'(BYTES)), oob, exp_rd[0], exp_rd[1]};
    ack_q.push_back(e);
    return e.cyc;
  endfunction

  task automatic set_req(input int id, input bit v);
    if (id == 0) a_req = v;
    else         b_req = v;
  endtask

  task automatic scramble(input int id);
    if (id == 0) begin
      a_wrt_enable = 1'($urandom); a_address = 8'($urandom); a_wrt_data = W'($urandom);
    end else begin
      b_wrt_enable = 1'($urandom); b_address = 8'($urandom); b_wrt_data = W'($urandom);
    end
  endtask

  // Requester behaviour: hold req until ack, then drop it; inputs churn after grant
  task automatic wait_ack(input int id, input bit en, input int g, input bit drop);
    bit done = 1'b0;
    if (!en) return;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if ((id == 0 && a_ack) || (id == 1 && b_ack)) begin
        done = 1'b1;
        set_req(id, 1'b0);
      end else begin
        if (cyc >= g) scramble(id);
        if (drop && cyc == g + 2) set_req(id, 1'b0);
      end
    end
    check(id == 0 ? "a_ack_timeout" : "b_ack_timeout", 64'(done), 64'(1));
  endtask

  task automatic run_phase(input bit en_a, input bit wr_a, input logic [7:0] ad_a, input logic [W-1:0] d_a,
                           input bit en_b, input bit wr_b, input logic [7:0] ad_b, input logic [W-1:0] d_b,
                           input bit drop_a);
    int order[$];
    int g;
    int gnt[2];
    @(posedge clk); #1;
    a_req = en_a; a_wrt_enable = wr_a; a_address = ad_a; a_wrt_data = d_a;
    b_req = en_b; b_wrt_enable = wr_b; b_address = ad_b; b_wrt_data = d_b;
    g = cyc + 1;
    gnt[0] = 0; gnt[1] = 0;
    if (en_a && en_b) order = (last_id == 1) ? '{0, 1} : '{1, 0};
    else if (en_a)    order = '{0};
    else if (en_b)    order = '{1};
    foreach (order[n]) begin
      int id = order[n];
      gnt[id] = g;
      if (id == 0) g = model_txn(0, wr_a, ad_a, d_a, g) + 2;
      else         g = model_txn(1, wr_b, ad_b, d_b, g) + 2;
    end
    fork
      wait_ack(0, en_a, gnt[0], drop_a);
      wait_ack(1, en_b, gnt[1], 1'b0);
    join
  endtask

  // Assert reset after two beats of a write have landed
  task automatic reset_mid();
    int start;
    @(posedge clk); #1;
    a_req = 1'b1; a_wrt_enable = 1'b1; a_address = 8'h40; a_wrt_data = W'(32'h44332211);
    start = cyc + 1;
    beat_q.push_back('{start,     8'h40, 8'h11});
    beat_q.push_back('{start + 1, 8'h41, 8'h22});
    ref_mem[8'h40] = 8'h11;
    ref_mem[8'h41] = 8'h22;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; a_req = 1'b0;
    #1 check("rst_mid_strobe_busy_ack", 64'({mem_wrt_enable, busy, a_ack}), 64'(0));
    repeat (2) @(posedge clk);
    #1 check("rst_mid_read_data", 64'({a_read_data, b_read_data}), 64'(0));
    rst_n = 1'b1;
    last_id = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    check("rst_mid_bytes", 64'({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}),
          64'({ref_mem[8'h43], ref_mem[8'h42], 8'h22, 8'h11}));
  endtask

  // Monitor: pops expected beats and acks whenever the DUT presents them
  beat_t      mb;
  ack_t       me;
  logic [1:0] who;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wrt_enable) begin
        if (beat_q.size() == 0) begin
          check("stray_strobe", 64'(mem_wrt_enable), 64'(0));
        end else begin
          mb = beat_q.pop_front();
          check("beat_cycle", 64'(cyc), 64'(mb.cyc));
          check("beat_addr", 64'(mem_address), 64'(mb.addr));
          check("beat_data", 64'(mem_wrt_data), 64'(mb.data));
        end
      end
      if (a_ack || b_ack) begin
        if (ack_q.size() == 0) begin
          check("stray_ack", 64'({a_ack, b_ack}), 64'(0));
        end else begin
          me  = ack_q.pop_front();
          who = (me.id == 0) ? 2'b10 : 2'b01;
          check("ack_owner", 64'({a_ack, b_ack}), 64'(who));
          check("ack_cycle", 64'(cyc), 64'(me.cyc));
          check("ack_err", 64'({a_err, b_err}), 64'(me.err ? who : 2'b00));
          check("a_read_data", 64'(a_read_data), 64'(me.rd_a));
          check("b_read_data", 64'(b_read_data), 64'(me.rd_b));
        end
      end else if (a_err || b_err) begin
        check("err_without_ack", 64'({a_err, b_err}), 64'(0));
      end
    end
  end

  logic [1:0] sel;
  int         diff;

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_wrt_enable = 1'b0; a_address = '0; a_wrt_data = '0;
    b_req = 1'b0; b_wrt_enable = 1'b0; b_address = '0; b_wrt_data = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({a_ack, b_ack, a_err, b_err, busy, mem_wrt_enable, mem_address, mem_wrt_data}), 64'(0));
    check("reset_read_data", 64'({a_read_data, b_read_data}), 64'(0));
    rst_n = 1'b1;

    run_phase(1'b1, 1'b1, 8'h10, 32'hDDCCBBAA, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    check("word_write_bytes", 64'({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}), 64'(32'hDDCCBBAA));
    run_phase(1'b0, 1'b0, 8'h00, '0, 1'b1, 1'b0, 8'h10, '0, 1'b0);
    check("b_read_word", 64'(b_read_data), 64'(32'hDDCCBBAA));

    run_phase(1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0);
    run_phase(1'b1, 1'b1, 8'h30, W'($urandom), 1'b1, 1'b0, 8'h20, '0, 1'b0);
    check("tie_b_read", 64'(b_read_data), 64'(32'h12345678));

    run_phase(1'b1, 1'b1, 8'hFE, 32'h44332211, 1'b0, 1'b0, 8'h00, '0, 1'b0);
`ifdef MEM_ARB_BOUNDS_EN
    check("oob_no_write", 64'({mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}),
          64'({ref_mem[8'h01], ref_mem[8'h00], ref_mem[8'hFF], ref_mem[8'hFE]}));
`else
    check("wrap_bytes", 64'({mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}), 64'(32'h44332211));
`endif

    run_phase(1'b1, 1'b1, 8'h50, W'($urandom), 1'b0, 1'b0, 8'h00, '0, 1'b1);
    run_phase(1'b1, 1'b0, 8'h50, '0, 1'b0, 1'b0, 8'h00, '0, 1'b1);

    repeat (40) begin
      sel = 2'($urandom_range(1, 3));
      run_phase(sel[0], 1'($urandom), 8'($urandom), W'($urandom),
                sel[1], 1'($urandom), 8'($urandom), W'($urandom), 1'b0);
    end

    reset_mid();
    run_phase(1'b1, 1'b0, 8'h40, '0, 1'b1, 1'b0, 8'h41, '0, 1'b0);
    run_phase(1'b1, 1'b1, 8'h60, W'($urandom), 1'b1, 1'b1, 8'h70, W'($urandom), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("beats_pending", 64'(beat_q.size()), 64'(0));
    check("acks_pending", 64'(ack_q.size()), 64'(0));
    check("idle_at_end", 64'({busy, mem_wrt_enable}), 64'(0));
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    check("mem_image", 64'(diff), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
